img_pxl_loader: RTL and testbench
=================================

# img_pxl_loader

Input-side feeder for the image edge detector top. Accepts a raster-ordered pixel stream over a valid/ready handshake and converts it into the detector's input frame-buffer write port (`frame_buf_in_wr_*`) with generated x/y coordinates. When a full frame has been written, it drives the detector's `run`, then holds off further input until the detector reports `done`.

## Interface
Parameters:
- `IMG_W`, 5: frame width in pixels (≥2).
- `IMG_H`, 5: frame height in pixels (≥2).
- `PXL_W`, 8: pixel width in bits.
- `X_W`, `$clog2(IMG_W)`: width of the x coordinate.
- `Y_W`, `$clog2(IMG_H)`: width of the y coordinate.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: an input pixel is offered.
- `s_ready` out 1: the loader can accept a pixel.
- `s_data` in `PXL_W`: pixel value.
- `s_last` in 1: marks the final pixel of the frame.
- `frame_buf_in_wr_en` out 1: write strobe to the input frame buffer.
- `frame_buf_in_wr_x` out `X_W`: column, 0..IMG_W-1.
- `frame_buf_in_wr_y` out `Y_W`: row, 0..IMG_H-1.
- `frame_buf_in_wr_data_pxl` out `PXL_W`: pixel written.
- `run` out 1: starts the detector (level).
- `done` in 1: detector finished (level).
- `frame_err` out 1: one-cycle framing-error pulse.
- `frame_cnt` out 8: count of frames handed to the detector; wraps 255→0.

## Operation
- A handshake occurs when `s_valid && s_ready` are both high at a rising edge of `clk`.
- FSM states are LOAD, START, RUN and DRAIN. Reset enters LOAD.
- **LOAD**
  - `s_ready`=1.
  - Each handshake registers a write of `s_data` at (x,y).
  - x increments on every handshake. At IMG_W-1, x wraps to 0 and y increments.
  - A handshake at (IMG_W-1, IMG_H-1) resets x,y to 0 and moves to START.
  - `s_valid` low: no write; counters hold.
- **START**
  - `s_ready`=0.
  - Exists only so that the last write lands before `run` rises.
  - Moves to RUN unconditionally.
- **RUN**
  - `run`=1, `s_ready`=0.
  - When `done`=1 is sampled: `frame_cnt`++ and move to DRAIN.
- **DRAIN**
  - `run`=0, `s_ready`=0.
  - Waits for `done`=0, then moves to LOAD.
- `done` is ignored in LOAD and START.
- `s_data` and `s_last` are don't-care when no handshake occurs.

## Timing
- Reset values: all outputs 0 (`s_ready`, `frame_buf_in_wr_en`, `frame_buf_in_wr_x`, `frame_buf_in_wr_y`, `frame_buf_in_wr_data_pxl`, `run`, `frame_err`, `frame_cnt`). Internal x, y and state also reset to 0.
- Only `s_ready` is high in the first cycle after reset release.
- All outputs are registered. `s_ready` is decoded from the state register only, with no combinational path from `s_valid`.
- Write latency: a handshake at edge N produces `wr_en`=1 with x, y and data during cycle N→N+1, for exactly one cycle per handshake.
- Back-to-back handshakes produce back-to-back writes; throughput is 1 pixel/clk.
- Final-pixel handshake at edge N:
  - write visible N→N+1;
  - state START in N→N+1;
  - `run`=1 from edge N+2.
- `done` sampled high at edge M: `run`=0 and `frame_cnt` updated from edge M+1.
- `s_ready` re-asserts one cycle after `done` is sampled low in DRAIN.
- Minimum frame period is IMG_W·IMG_H + 3 cycles + detector time.
- Asynchronous reset mid-frame:
  - immediate return to reset values;
  - partial frame abandoned;
  - `run` drops at once.
  - The detector is expected to be reset by the same `rst_n`.

## Configuration
- Macro: `IMG_PXL_LOADER_LAST_CHECK_EN`.
- **Defined** (`s_last` framing is checked):
  - `s_last`=1 on a handshake before the final pixel: that pixel is still written; `frame_err` pulses the following cycle; x,y reset to 0; state stays LOAD. The partial frame is discarded and overwritten.
  - Final pixel accepted with `s_last`=0: `frame_err` pulses and the frame proceeds normally to START.
- **Not defined**: `s_last` is ignored, `frame_err` is tied to 0, and only the counters delimit frames.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0; `s_ready`=1 the cycle after release.
- **Full 5x5 frame:** 5x5 diagonal frame (250..254 on the diagonal, 0 elsewhere), `s_valid` continuous →
  - 25 consecutive writes, (0,0)=250 … (4,4)=254;
  - `run` rises 2 cycles after the 25th handshake;
  - `s_ready`=0 until `done` cycles high then low;
  - `frame_cnt`=1.
- **Gaps and backpressure:**
  - `s_valid` toggling 1/0 → writes only on handshake cycles, coordinates continuous.
  - `s_valid` held in RUN and DRAIN → no writes.
- **Early `s_last`** (macro defined): `s_last` on the 7th pixel → `frame_err` pulses once. The next pixel is written at (0,0), and `run` follows only after 25 further pixels.
- **Reset mid-frame:** `rst_n` pulsed low after 12 pixels → `wr_en` and `run` go to 0 immediately. The next frame starts at (0,0); `frame_cnt`=0.
- **Counter wrap:** 256 frames with `done` pulsed → `frame_cnt` wraps to 0; no `frame_err` with correct `s_last`.

Source files
------------

// File: rtl/img_pxl_loader.sv
// img_pxl_loader: raster pixel stream -> detector input frame-buffer writes, then run/done handoff.
// Define IMG_PXL_LOADER_LAST_CHECK_EN to check s_last framing and drive frame_err.
module img_pxl_loader #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int PXL_W = 8,
  parameter int X_W   = $clog2(IMG_W),
  parameter int Y_W   = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PXL_W-1:0] s_data,
  input  logic             s_last,
  output logic             frame_buf_in_wr_en,
  output logic [X_W-1:0]   frame_buf_in_wr_x,
  output logic [Y_W-1:0]   frame_buf_in_wr_y,
  output logic [PXL_W-1:0] frame_buf_in_wr_data_pxl,
  output logic             run,
  input  logic             done,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

  state_t         state, next_state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           hs;
  logic           at_end;
  logic           early_last;
  logic           done_hit;
  logic           ready_d;
  logic           run_d;

  // s_ready is a flop equal to (state == LOAD) after the first edge, so it can gate the handshake.
  assign hs     = s_valid && s_ready;
  assign at_end = (x == X_MAX) && (y == Y_MAX);

`ifdef IMG_PXL_LOADER_LAST_CHECK_EN
  assign early_last = s_last && !at_end;
`else
  logic unused_last;
  assign early_last  = 1'b0;
  assign unused_last = s_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      LOAD:    if (hs && at_end) next_state = START;
      START:   next_state = RUN;
      RUN:     if (done) next_state = DRAIN;
      DRAIN:   if (!done) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Registered outputs are computed one cycle early from the state decode.
  always_comb begin
    ready_d = (next_state == LOAD);
    run_d   = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready                  <= 1'b0;
      run                      <= 1'b0;
      frame_buf_in_wr_en       <= 1'b0;
      frame_buf_in_wr_x        <= '0;
      frame_buf_in_wr_y        <= '0;
      frame_buf_in_wr_data_pxl <= '0;
      x                        <= '0;
      y                        <= '0;
      done_hit                 <= 1'b0;
      frame_cnt                <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      s_ready            <= ready_d;
      run                <= run_d;
      frame_buf_in_wr_en <= hs;
      done_hit           <= (state == RUN) && done;
      frame_cnt          <= frame_cnt + 8'(done_hit);
      if (hs) begin
        frame_buf_in_wr_x        <= x;
        frame_buf_in_wr_y        <= y;
        frame_buf_in_wr_data_pxl <= s_data;
        if (at_end || early_last) begin
          x <= '0;
          y <= '0;
        end else if (x == X_MAX) begin
          x <= '0;
          y <= y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

`ifdef IMG_PXL_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= hs && (s_last != at_end);
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_img_pxl_loader.sv
// Self-checking bench for img_pxl_loader: vector table, directed corner cases and a
// per-cycle reference model driven by randomized pixel/gap/detector timing.
module tb_img_pxl_loader;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int NPIX = W * H;
  localparam int BOUND = 1000;

`ifdef IMG_PXL_LOADER_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [PW-1:0] s_data = '0;
  logic          done = 1'b0;
  logic          s_ready;
  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [PW-1:0] wr_data;
  logic          run;
  logic          frame_err;
  logic [7:0]    frame_cnt;

  img_pxl_loader #(.IMG_W(W), .IMG_H(H), .PXL_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .frame_buf_in_wr_en(wr_en), .frame_buf_in_wr_x(wr_x), .frame_buf_in_wr_y(wr_y),
    .frame_buf_in_wr_data_pxl(wr_data),
    .run(run), .done(done), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 loading, 1 settle, 2 detector running, 3 waiting for done to drop.
  int         m_phase = 0;
  int         m_idx = 0;
  bit         m_inc = 1'b0;
  bit         mon_en = 1'b0;
  logic       e_ready = 0, e_wr = 0, e_run = 0, e_err = 0;
  logic [7:0] e_x = 0, e_y = 0, e_data = 0, e_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_inc = 0;
      e_ready = 0; e_wr = 0; e_run = 0; e_err = 0;
      e_x = 0; e_y = 0; e_data = 0; e_cnt = 0;
    end else begin
      bit hs;
      bit final_pix;
      hs        = s_valid && e_ready;
      final_pix = (m_idx == NPIX - 1);
      e_wr      = hs;
      e_err     = hs && CHK && (s_last != final_pix);
      e_run     = (m_phase == 2);
      e_cnt     = e_cnt + 8'(m_inc);
      m_inc     = (m_phase == 2) && done;
      if (hs) begin
        e_x    = 8'(m_idx % W);
        e_y    = 8'(m_idx / W);
        e_data = s_data;
      end
      case (m_phase)
        0: if (hs) begin
             if (final_pix) begin m_idx = 0; m_phase = 1; end
             else if (CHK && s_last) m_idx = 0;
             else m_idx++;
           end
        1: m_phase = 2;
        2: if (done) m_phase = 3;
        default: if (!done) m_phase = 0;
      endcase
      e_ready = (m_phase == 0);
    end
  end

  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      check("m_ready", s_ready, e_ready);
      check("m_wr_en", wr_en, e_wr);
      check("m_wr_x", wr_x, e_x);
      check("m_wr_y", wr_y, e_y);
      check("m_wr_data", wr_data, e_data);
      check("m_run", run, e_run);
      check("m_frame_err", frame_err, e_err);
      check("m_frame_cnt", frame_cnt, e_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_pix(input logic [7:0] d, input bit last);
    int t;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = last;
    t = 0;
    while (!s_ready && t < BOUND) begin @(negedge clk); t++; end
    check("ready_timeout", (t >= BOUND), 0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
    end
  endtask

  // mode 0: diagonal image, continuous; mode 1: random data with random gaps.
  task automatic send_frame(input int mode, input int first);
    for (int k = first; k < NPIX; k++) begin
      logic [7:0] d;
      if (mode == 0) d = ((k % W) == (k / W)) ? 8'(250 + k % W) : 8'd0;
      else d = 8'($urandom);
      send_pix(d, (k == NPIX - 1));
      if (mode == 1 && k != NPIX - 1 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // Acts as the detector; keeps s_valid asserted through RUN/DRAIN to show it is ignored.
  task automatic serve(input int lat, input int hold);
    int t;
    t = 0;
    while (!run && t < BOUND) begin @(negedge clk); t++; end
    check("run_timeout", (t >= BOUND), 0);
    repeat (lat) @(negedge clk);
    done = 1'b1;
    t = 0;
    while (run && t < BOUND) begin @(negedge clk); t++; end
    check("run_drop_timeout", (t >= BOUND), 0);
    repeat (hold) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    t = 0;
    while (!s_ready && t < BOUND) begin @(negedge clk); t++; end
    check("reready_timeout", (t >= BOUND), 0);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         rdy;
    bit         wr;
    int         x;
    int         y;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 8'd10, 1, 0, 0, 0, 8'd0};
    tbl[1] = '{1, 8'd11, 1, 1, 0, 0, 8'd11};
    tbl[2] = '{0, 8'd99, 1, 0, 0, 0, 8'd11};
    tbl[3] = '{1, 8'd12, 1, 1, 1, 0, 8'd12};
    tbl[4] = '{1, 8'd13, 1, 1, 2, 0, 8'd13};
    tbl[5] = '{0, 8'd77, 1, 0, 2, 0, 8'd13};
    tbl[6] = '{1, 8'd14, 1, 1, 3, 0, 8'd14};
    tbl[7] = '{1, 8'd15, 1, 1, 4, 0, 8'd15};
    tbl[8] = '{1, 8'd16, 1, 1, 0, 1, 8'd16};

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", s_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_x", wr_x, 0);
    check("rst_y", wr_y, 0);
    check("rst_data", wr_data, 0);
    check("rst_run", run, 0);
    check("rst_err", frame_err, 0);
    check("rst_cnt", frame_cnt, 0);
    mon_en = 1'b1;

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; s_last = 1'b0;
      @(negedge clk);
      check("tbl_ready", s_ready, tbl[i].rdy);
      check("tbl_wr_en", wr_en, tbl[i].wr);
      check("tbl_x", wr_x, tbl[i].x);
      check("tbl_y", wr_y, tbl[i].y);
      check("tbl_data", wr_data, tbl[i].dat);
      check("tbl_run", run, 0);
    end
    s_valid = 1'b0;
    send_frame(1, 6);
    serve(2, 1);
    check("cnt_after_f1", frame_cnt, 1);

    // Diagonal frame, continuous valid; run must rise two edges after the last handshake.
    send_frame(0, 0);
    #1;
    check("diag_last_x", wr_x, 4);
    check("diag_last_y", wr_y, 4);
    check("diag_last_data", wr_data, 254);
    @(negedge clk);
    check("diag_run_n1", run, 0);
    check("diag_ready_n1", s_ready, 0);
    @(negedge clk);
    check("diag_run_n2", run, 0);
    @(negedge clk);
    check("diag_run_n3", run, 1);
    serve(3, 2);
    check("cnt_after_f2", frame_cnt, 2);

    // Random gaps and random detector latency.
    for (int f = 0; f < 3; f++) begin
      send_frame(1, 0);
      serve($urandom_range(0, 6), $urandom_range(0, 3));
    end
    check("cnt_after_gaps", frame_cnt, 5);

`ifdef IMG_PXL_LOADER_LAST_CHECK_EN
    // Early s_last on the 7th pixel restarts the frame at (0,0).
    for (int k = 0; k < 7; k++) send_pix(8'($urandom), (k == 6));
    idle(1);
    #1;
    check("early_err_pulse", frame_err, 1);
    @(negedge clk);
    check("early_err_once", frame_err, 0);
    send_pix(8'h5a, 1'b0);
    #1;
    check("early_restart_x", wr_x, 0);
    check("early_restart_y", wr_y, 0);
    send_frame(1, 1);
    serve(1, 1);
    check("cnt_after_early", frame_cnt, 6);
`endif

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 12; k++) send_pix(8'($urandom), 1'b0);
    #2;
    check("mid_wr_en_pre", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_wr_en_rst", wr_en, 0);
    check("mid_ready_rst", s_ready, 0);
    check("mid_cnt_rst", frame_cnt, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while run is high drops run at once.
    send_frame(0, 0);
    begin
      int t;
      t = 0;
      while (!run && t < BOUND) begin @(negedge clk); t++; end
      check("rst_run_timeout", (t >= BOUND), 0);
    end
    check("run_pre_rst", run, 1);
    rst_n = 1'b0;
    #1;
    check("run_rst", run, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 256 frames: counter reaches 255 then wraps to 0.
    for (int f = 0; f < 256; f++) begin
      send_frame(0, 0);
      serve(0, 0);
      if (f == 0) check("post_rst_cnt", frame_cnt, 1);
      if (f == 254) check("cnt_255", frame_cnt, 255);
    end
    check("cnt_wrap", frame_cnt, 0);

    mon_en = 1'b0;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
